// File: rtl/fp_pkg.sv
// Shared types and constants for the softmax FP multiplier arbiter.
// State encoding is fixed so that debug probes and traces stay stable.
package fp_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT   = 3'd1,
    SEND_A  = 3'd2,
    SEND_B  = 3'd3,
    WAIT_Z  = 3'd4,
    DELIVER = 3'd5
  } state_t;

  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_QNAN = 32'hFFC0_0000;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first set request bit at or
// after ptr, searching upward with wrap.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           found,
  output logic [IDW-1:0] index
);

  logic [IDW:0]   sum;
  logic [IDW-1:0] cand;

  // Descending scan so the candidate closest to ptr is written last and wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    sum   = '0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IDW + 1)'(k);
      if (sum >= (IDW + 1)'(N)) begin
        sum = sum - (IDW + 1)'(N);
      end else begin
        sum = sum;
      end
      cand = sum[IDW-1:0];
      if (req[cand]) begin
        found = 1'b1;
        index = cand;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin sharing of one FP32 multiplier core among NUM_REQ requesters;
// one operation in flight, result returned to the requester that issued it.
module fp_mul_arbiter
  import fp_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ),
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ-1:0]    req_stb,
  output logic [NUM_REQ-1:0]    req_ack,
  output logic [31:0]           res_z,
  output logic [NUM_REQ-1:0]    res_stb,
  input  logic [NUM_REQ-1:0]    res_ack,
  output logic [31:0]           mul_a,
  output logic [31:0]           mul_b,
  output logic                  mul_a_stb,
  output logic                  mul_b_stb,
  input  logic                  mul_a_ack,
  input  logic                  mul_b_ack,
  input  logic [31:0]           mul_z,
  input  logic                  mul_z_stb,
  output logic                  mul_z_ack,
  output logic                  busy,
  output logic [IDW-1:0]        grant_id,
  output logic [CNT_W-1:0]      op_count
);

  state_t         state;
  state_t         state_next;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] ptr_inc;
  logic [IDW-1:0] pick_idx;
  logic           pick_found;
  logic [31:0]    a_sel;
  logic [31:0]    b_sel;

  rr_pick #(.N(NUM_REQ), .IDW(IDW)) u_pick (
    .req   (req_stb),
    .ptr   (ptr),
    .found (pick_found),
    .index (pick_idx)
  );

  assign ptr_inc = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);

  // Operand slice of the granted requester.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == IDW'(i)) begin
        a_sel = req_a[32*i +: 32];
        b_sel = req_b[32*i +: 32];
      end else begin
        a_sel = a_sel;
        b_sel = b_sel;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = pick_found ? GRANT : IDLE;
      GRANT:   state_next = req_stb[grant_id] ? SEND_A : IDLE;
      SEND_A:  state_next = (mul_a_stb && mul_a_ack) ? SEND_B : SEND_A;
      SEND_B:  state_next = (mul_b_stb && mul_b_ack) ? WAIT_Z : SEND_B;
      WAIT_Z:  state_next = mul_z_stb ? DELIVER : WAIT_Z;
      DELIVER: state_next = res_ack[grant_id] ? IDLE : DELIVER;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    req_ack   = '0;
    mul_z_ack = 1'b0;
    busy      = (state != IDLE);
    case (state)
      GRANT:   req_ack[grant_id] = req_stb[grant_id];
      WAIT_Z:  mul_z_ack = 1'b1;
      default: mul_z_ack = 1'b0;
    endcase
  end

  // Datapath and bookkeeping registers; a dropped request in GRANT leaves ptr as is.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_id  <= '0;
      ptr       <= '0;
      op_count  <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_a_stb <= 1'b0;
      mul_b_stb <= 1'b0;
      res_z     <= '0;
      res_stb   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) grant_id <= pick_idx;
        end
        GRANT: begin
          if (req_stb[grant_id]) begin
            mul_a     <= a_sel;
            mul_b     <= b_sel;
            mul_a_stb <= 1'b1;
          end
        end
        SEND_A: begin
          if (mul_a_stb && mul_a_ack) begin
            mul_a_stb <= 1'b0;
            mul_b_stb <= 1'b1;
          end
        end
        SEND_B: begin
          if (mul_b_stb && mul_b_ack) mul_b_stb <= 1'b0;
        end
        WAIT_Z: begin
          if (mul_z_stb) begin
            res_z             <= mul_z;
            res_stb[grant_id] <= 1'b1;
          end
        end
        DELIVER: begin
          if (res_ack[grant_id]) begin
            res_stb  <= '0;
            ptr      <= ptr_inc;
            op_count <= op_count + CNT_W'(1);
          end
        end
        default: begin
          res_stb <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter with a stub multiplier core answering
// from a table of hand-computed FP32 products.
module tb_fp_mul_arbiter;
  import fp_pkg::*;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*32-1:0] req_a, req_b;
  logic [N-1:0]   req_stb, req_ack, res_stb, res_ack;
  logic [31:0]    res_z, mul_a, mul_b, mul_z;
  logic           mul_a_stb, mul_b_stb, mul_a_ack, mul_b_ack, mul_z_stb, mul_z_ack;
  logic           busy;
  logic [1:0]     grant_id;
  logic [15:0]    op_count;

  int pass_cnt = 0;
  int total    = 0;
  int exp_ops  = 0;
  int last_wait;
  int zdelay   = 0;

  always #5 clk = ~clk;

  fp_mul_arbiter #(.NUM_REQ(N), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .req_stb(req_stb),
    .req_ack(req_ack), .res_z(res_z), .res_stb(res_stb), .res_ack(res_ack),
    .mul_a(mul_a), .mul_b(mul_b), .mul_a_stb(mul_a_stb), .mul_b_stb(mul_b_stb),
    .mul_a_ack(mul_a_ack), .mul_b_ack(mul_b_ack), .mul_z(mul_z),
    .mul_z_stb(mul_z_stb), .mul_z_ack(mul_z_ack), .busy(busy),
    .grant_id(grant_id), .op_count(op_count)
  );

  // Stub core: products for the operand pairs used below.
  function automatic logic [31:0] core_mul(input logic [31:0] a, input logic [31:0] b);
    if (a == FP_ONE) return b;
    case ({a, b})
      {32'h4000_0000, 32'h4040_0000}: return 32'h40C0_0000;
      {32'h3FC0_0000, 32'h3FC0_0000}: return 32'h4010_0000;
      {32'h7F80_0000, 32'h0000_0000}: return FP_QNAN;
      {32'hC000_0000, 32'h4000_0000}: return 32'hC080_0000;
      default:                        return 32'h7FC0_0001;
    endcase
  endfunction

  logic [31:0] ca, cb;
  logic        pend;
  int          cnt;
  assign mul_a_ack = mul_a_stb;
  assign mul_b_ack = mul_b_stb;
  assign mul_z     = core_mul(ca, cb);

  always @(posedge clk) begin
    if (rst) begin
      ca <= '0; cb <= '0; pend <= 1'b0; mul_z_stb <= 1'b0; cnt <= 0;
    end else begin
      if (mul_a_stb && mul_a_ack) ca <= mul_a;
      if (mul_b_stb && mul_b_ack) begin
        cb <= mul_b; pend <= 1'b1; cnt <= zdelay;
      end else if (pend && !mul_z_stb) begin
        if (cnt == 0) mul_z_stb <= 1'b1;
        else cnt <= cnt - 1;
      end
      if (mul_z_stb && mul_z_ack) begin
        mul_z_stb <= 1'b0; pend <= 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_stb = '0;
    res_ack = '0;
    @(negedge clk);
    rst = 1'b0;
    exp_ops = 0;
  endtask

  // Serve the next granted operation; optionally drop that requester's strobe after its ack.
  task automatic run_one(input logic drop, input logic [31:0] exp_z, output int idx);
    int n;
    idx = -1;
    n = 0;
    while (req_ack == '0 && n < 40) begin @(negedge clk); n++; end
    last_wait = n;
    if (req_ack == '0) begin chk("req_ack_timeout", 32'd0, 32'd1); return; end
    for (int i = 0; i < N; i++) if (req_ack[i]) idx = i;
    chk("req_ack_onehot", 32'(req_ack), 32'(1) << idx);
    @(negedge clk);
    chk("req_ack_pulse", 32'(req_ack), 32'd0);
    if (drop) req_stb[idx] = 1'b0;
    n = 0;
    while (res_stb == '0 && n < 60) begin @(negedge clk); n++; end
    if (res_stb == '0) begin chk("res_stb_timeout", 32'd0, 32'd1); return; end
    chk("res_stb_onehot", 32'(res_stb), 32'(1) << idx);
    chk("res_z", res_z, exp_z);
    chk("grant_id", 32'(grant_id), 32'(idx));
    res_ack[idx] = 1'b1;
    @(negedge clk);
    res_ack[idx] = 1'b0;
    exp_ops++;
    chk("busy_after_ack", 32'(busy), 32'd0);
    chk("res_stb_cleared", 32'(res_stb), 32'd0);
  endtask

  task automatic do_op(input int r, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] z);
    int idx;
    req_a[32*r +: 32] = a;
    req_b[32*r +: 32] = b;
    req_stb[r] = 1'b1;
    run_one(1'b1, z, idx);
    chk("grant_index", 32'(idx), 32'(r));
    chk("ack_latency", 32'(last_wait), 32'd1);
  endtask

  typedef struct {
    int          r;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
  } vec_t;

  vec_t tv[5];

  initial begin
    int idx;
    int n;
    int order[5];
    tv[0] = '{0, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000};
    tv[1] = '{1, 32'h7F80_0000, 32'h0000_0000, 32'hFFC0_0000};
    tv[2] = '{2, 32'hC000_0000, 32'h4000_0000, 32'hC080_0000};
    tv[3] = '{3, 32'h3F80_0000, 32'h7F80_0000, 32'h7F80_0000};
    tv[4] = '{0, 32'h3F80_0000, 32'h0000_0000, 32'h0000_0000};
    order = '{0, 1, 2, 3, 0};

    rst = 1'b1; req_a = '0; req_b = '0; req_stb = '0; res_ack = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_strobes", {res_stb, req_ack, 20'd0, mul_a_stb, mul_b_stb, mul_z_ack, 1'b0}, 32'd0);
    chk("rst_mul_a", mul_a, 32'd0);
    chk("rst_res_z", res_z, 32'd0);

    foreach (tv[i]) do_op(tv[i].r, tv[i].a, tv[i].b, tv[i].z);
    chk("op_count_table", 32'(op_count), 32'(exp_ops));

    // Backpressure on requester 2 with a late request from 1 and a stray ack on 0.
    req_a[64 +: 32] = 32'h4000_0000; req_b[64 +: 32] = 32'h4040_0000; req_stb[2] = 1'b1;
    n = 0;
    while (req_ack[2] == 1'b0 && n < 40) begin @(negedge clk); n++; end
    chk("bp_grant", 32'(req_ack), 32'h4);
    @(negedge clk);
    req_stb[2] = 1'b0; req_stb[1] = 1'b1;
    n = 0;
    while (res_stb == '0 && n < 60) begin @(negedge clk); n++; end
    res_ack[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("bp_res_stb", 32'(res_stb), 32'h4);
      chk("bp_res_z", res_z, 32'h40C0_0000);
      if (req_ack != '0 || busy != 1'b1) chk("bp_no_grant", {req_ack, 3'd0, busy}, 32'd1);
    end
    res_ack = 4'b0100;
    @(negedge clk);
    res_ack = '0; req_stb[1] = 1'b0; exp_ops++;
    chk("bp_busy_drop", 32'(busy), 32'd0);
    chk("bp_op_count", 32'(op_count), 32'(exp_ops));

    // Pointer fairness: after 3 completes, 0 wins over 3.
    do_op(3, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
    req_a[0 +: 32] = 32'hC000_0000;  req_b[0 +: 32] = 32'h4000_0000;
    req_a[96 +: 32] = 32'h3FC0_0000; req_b[96 +: 32] = 32'h3FC0_0000;
    req_stb = 4'b1001;
    run_one(1'b1, 32'hC080_0000, idx);
    chk("fair_first", 32'(idx), 32'd0);
    run_one(1'b1, 32'h4010_0000, idx);
    chk("fair_second", 32'(idx), 32'd3);
    chk("fair_op_count", 32'(op_count), 32'(exp_ops));

    // Round robin with every requester holding its strobe.
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = 32'h3FC0_0000; req_b[32*i +: 32] = 32'h3FC0_0000;
    end
    req_stb = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      run_one(1'b0, 32'h4010_0000, idx);
      chk("rr_order", 32'(idx), 32'(order[k]));
    end
    req_stb = '0;
    chk("rr_op_count", 32'(op_count), 32'(exp_ops));

    // Reset while waiting for the core result.
    zdelay = 10;
    req_a[32 +: 32] = 32'h4000_0000; req_b[32 +: 32] = 32'h4040_0000; req_stb[1] = 1'b1;
    n = 0;
    while (mul_z_ack == 1'b0 && n < 40) begin @(negedge clk); n++; end
    chk("wz_reached", 32'(mul_z_ack), 32'd1);
    rst = 1'b1; req_stb = '0;
    @(negedge clk);
    rst = 1'b0; exp_ops = 0;
    chk("wz_rst_strobes", {res_stb, req_ack, 20'd0, mul_a_stb, mul_b_stb, mul_z_ack, busy}, 32'd0);
    chk("wz_rst_op_count", 32'(op_count), 32'd0);
    chk("wz_rst_grant", 32'(grant_id), 32'd0);
    zdelay = 0;
    do_op(1, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
    chk("wz_op_count", 32'(op_count), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
